// File: rtl/keypad_pw_pkg.sv
// Shared types, key codes and the row/col to key-code map for the keypad scanner.
package keypad_pw_pkg;

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_EMIT     = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  localparam logic [3:0] COL_RST  = 4'b1110;
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Physical layout: rows top to bottom, columns left to right.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_A;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_B;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic logic key_is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // True when exactly one active-low row is asserted.
  function automatic logic one_low(input logic [3:0] rows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + 3'(~rows[i]);
    return n == 3'd1;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_pw_scan_if.sv
// Keypad matrix lines plus the key-code strobe bus toward the password FSM.
interface keypad_pw_scan_if #(parameter int unsigned Bits = 4);
  logic [3:0]      row_in;
  logic [3:0]      col_out;
  logic [Bits-1:0] entrada_pw;
  logic            enable_data;
  logic            key_held;

  modport master (input row_in, output col_out, entrada_pw, enable_data, key_held);
  modport slave  (output row_in, input col_out, entrada_pw, enable_data, key_held);
endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous row lines; resets to idle (all high).
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:0] row_async,
  output logic [3:0] row_sync
);
  import keypad_pw_pkg::*;

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      meta     <= ROW_IDLE;
      row_sync <= ROW_IDLE;
    end else begin
      meta     <= row_async;
      row_sync <= meta;
    end
  end
endmodule

// File: rtl/keypad_pw_scan.sv
// 4x4 keypad scanner/debouncer emitting one enable_data strobe per accepted press.
// Optional feature macro KEYPAD_PW_HEX_EN: when defined, A-D/*/# also strobe.
module keypad_pw_scan
  import keypad_pw_pkg::*;
#(
  parameter int unsigned Bits         = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input logic              clk,
  input logic              rst_a,
  keypad_pw_scan_if.master bus
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);

`ifdef KEYPAD_PW_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  state_t          state;
  logic [DW-1:0]   dwell;
  logic [CW-1:0]   cnt;
  logic [3:0]      row_s;
  logic [3:0]      row_lat;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic [3:0]      col_q;
  logic [Bits-1:0] code_q;
  logic            strobe_q;
  logic            held_q;
  logic [3:0]      key_c;
  logic            accept_c;
  logic            dwell_end_c;
  logic            cnt_end_c;

  keypad_row_sync u_sync (
    .clk       (clk),
    .rst_a     (rst_a),
    .row_async (bus.row_in),
    .row_sync  (row_s)
  );

  assign key_c       = key_code(row_idx, col_idx);
  assign accept_c    = HEX_EN || key_is_digit(key_c);
  assign dwell_end_c = (dwell == DW'(SCAN_DIV - 1));
  assign cnt_end_c   = (cnt == CW'(DEBOUNCE_CYC - 1));

  assign bus.col_out     = col_q;
  assign bus.entrada_pw  = code_q;
  assign bus.enable_data = strobe_q;
  assign bus.key_held    = held_q;

  // Column rotation, debounce counting and strobe generation share one state register.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      state    <= ST_SCAN;
      dwell    <= '0;
      cnt      <= '0;
      row_lat  <= ROW_IDLE;
      row_idx  <= 2'd0;
      col_idx  <= 2'd0;
      col_q    <= COL_RST;
      code_q   <= '0;
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (dwell_end_c) begin
            dwell <= '0;
            if (one_low(row_s)) begin
              row_lat <= row_s;
              row_idx <= row_index(row_s);
              cnt     <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              col_q   <= {col_q[2:0], col_q[3]};
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (row_s != row_lat) begin
            cnt     <= '0;
            col_q   <= {col_q[2:0], col_q[3]};
            col_idx <= col_idx + 2'd1;
            state   <= ST_SCAN;
          end else if (cnt_end_c) begin
            cnt    <= '0;
            held_q <= 1'b1;
            state  <= ST_EMIT;
            // Non-accepted keys still occupy the held/release cycle, silently.
            if (accept_c) begin
              strobe_q <= 1'b1;
              code_q   <= Bits'(key_c);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_EMIT: state <= ST_HELD;
        ST_HELD: begin
          if (row_s == ROW_IDLE) begin
            cnt   <= '0;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (row_s != ROW_IDLE) begin
            cnt   <= '0;
            state <= ST_HELD;
          end else if (cnt_end_c) begin
            cnt     <= '0;
            held_q  <= 1'b0;
            col_q   <= {col_q[2:0], col_q[3]};
            col_idx <= col_idx + 2'd1;
            state   <= ST_SCAN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_pw_scan.sv
// Scoreboard bench for keypad_pw_scan: directed key presses, queued expected codes.
module tb_keypad_pw_scan;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic [15:0] pressed = 16'h0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          strobe_cyc = 0;
  int          t_last = 0;
  logic [3:0]  exp_q[$];

  keypad_pw_scan_if #(.Bits(4)) bus ();

  keypad_pw_scan #(.Bits(4), .SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix: a row reads low when any pressed key in it sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++)
      bus.row_in[r] = ~|(pressed[r*4 +: 4] & ~bus.col_out);
  end

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (bus.enable_data === 1'b1) begin
      strobe_cyc = cyc;
      check("key_held_at_strobe", int'(bus.key_held), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", int'(bus.entrada_pw), -1);
      end else begin
        check("strobe_code", int'(bus.entrada_pw), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
  endtask

  task automatic press(input int idx, input int hold, input int idle, input bit expect_strobe,
                       input logic [3:0] code);
    if (expect_strobe) exp_q.push_back(code);
    pressed[idx] = 1'b1;
    cycles(hold);
    check_drained("press_drained");
    pressed[idx] = 1'b0;
    cycles(idle);
  endtask

  initial begin
    // Reset and column rotation
    cycles(3);
    check("rst_col", int'(bus.col_out), 4'b1110);
    check("rst_code", int'(bus.entrada_pw), 0);
    check("rst_en", int'(bus.enable_data), 0);
    check("rst_held", int'(bus.key_held), 0);
    rst_a = 1'b0;
    cycles(3);
    check("col_dwell", int'(bus.col_out), 4'b1110);
    cycles(1);
    check("col_step1", int'(bus.col_out), 4'b1101);
    cycles(4);
    check("col_step2", int'(bus.col_out), 4'b1011);
    cycles(4);
    check("col_step3", int'(bus.col_out), 4'b0111);
    cycles(4);
    check("col_wrap", int'(bus.col_out), 4'b1110);

    // Key 6 held long, then release
    exp_q.push_back(4'd6);
    pressed[6] = 1'b1;
    cycles(60);
    check_drained("key6_drained");
    check("key6_held", int'(bus.key_held), 1);
    pressed[6] = 1'b0;
    cycles(5);
    check("key6_held_after_rel", int'(bus.key_held), 1);
    cycles(15);
    check("key6_released", int'(bus.key_held), 0);
    cycles(20);

    // Key 9 bouncing, then stable
    for (int i = 0; i < 10; i++) begin
      pressed[10] = (i % 2 == 0);
      cycles(3);
    end
    exp_q.push_back(4'd9);
    pressed[10] = 1'b1;
    t_last = cyc;
    cycles(40);
    check_drained("key9_drained");
    check("key9_latency_ok", int'(strobe_cyc >= t_last + 8), 1);
    pressed[10] = 1'b0;
    cycles(40);

    // Sequence 6, 9, 8, 7
    press(6, 40, 40, 1'b1, 4'd6);
    press(10, 40, 40, 1'b1, 4'd9);
    press(9, 40, 40, 1'b1, 4'd8);
    press(8, 40, 40, 1'b1, 4'd7);
    check("seq_last_code", int'(bus.entrada_pw), 7);

    // Ghost: 1 and 4 share column 0
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    cycles(60);
    check("ghost_held", int'(bus.key_held), 0);
    check("ghost_code", int'(bus.entrada_pw), 7);
    exp_q.push_back(4'd1);
    pressed[4] = 1'b0;
    cycles(40);
    check_drained("ghost_key1_drained");
    pressed[0] = 1'b0;
    cycles(40);

    // Hash key
`ifdef KEYPAD_PW_HEX_EN
    exp_q.push_back(4'd15);
`endif
    pressed[14] = 1'b1;
    cycles(40);
    check("hash_held", int'(bus.key_held), 1);
    check_drained("hash_drained");
    pressed[14] = 1'b0;
    cycles(40);
    check("hash_released", int'(bus.key_held), 0);
`ifdef KEYPAD_PW_HEX_EN
    check("hash_code", int'(bus.entrada_pw), 15);
`else
    check("hash_code_unchanged", int'(bus.entrada_pw), 1);
`endif

    // Key 5 with reset while held
    exp_q.push_back(4'd5);
    pressed[5] = 1'b1;
    cycles(40);
    check_drained("key5_drained");
    rst_a = 1'b1;
    cycles(1);
    check("midrst_col", int'(bus.col_out), 4'b1110);
    check("midrst_code", int'(bus.entrada_pw), 0);
    check("midrst_en", int'(bus.enable_data), 0);
    check("midrst_held", int'(bus.key_held), 0);
    rst_a = 1'b0;
    exp_q.push_back(4'd5);
    cycles(40);
    check_drained("key5_restrobe_drained");
    check("key5_code", int'(bus.entrada_pw), 5);
    pressed[5] = 1'b0;
    cycles(40);
    check("final_idle_held", int'(bus.key_held), 0);
    check_drained("final_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
